jt49_mix3: RTL

- Three-channel PSG amplitude mixer.
- Converts the three 5-bit logarithmic channel volumes into linear amplitudes through a fixed 32-entry table.
- Sums the amplitudes sequentially over several clocks and applies a gain.
- Delivers one saturated unsigned 8-bit sample plus a one-cycle strobe, which directly drive the DC-removal stage's din/cen inputs.

---
 rtl/jt49_mix3.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/jt49_mix3.sv
// jt49_mix3: three-channel PSG mixer; log volume -> linear ROM, sequential sum, gain, saturate.
// Define JT49_MIX_PEAK_EN to add a peak-hold register (peak_clr input, peak output).
module jt49_mix3 #(
  parameter int unsigned GAIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [4:0] vola,
  input  logic [4:0] volb,
  input  logic [4:0] volc,
  input  logic [2:0] mute,
`ifdef JT49_MIX_PEAK_EN
  input  logic       peak_clr,
  output logic [7:0] peak,
`endif
  output logic [7:0] dout,
  output logic       dout_cen
);

  typedef enum logic [2:0] {IDLE, ACC_A, ACC_B, ACC_C, OUT} state_t;

  localparam logic [3:0] GAIN_W = 4'(GAIN);

  if (GAIN == 0 || GAIN > 15) begin : g_gain_check
    $error("jt49_mix3: GAIN must be in 1..15");
  end

  // lut[n] = round(255 * 10^(-(31-n)*1.5/20)), 1.5 dB per step, lut[0] silent
  function automatic logic [7:0] lut(input logic [4:0] n);
    case (n)
      5'd31: lut = 8'd255;  5'd30: lut = 8'd215;  5'd29: lut = 8'd181;  5'd28: lut = 8'd152;
      5'd27: lut = 8'd128;  5'd26: lut = 8'd108;  5'd25: lut = 8'd90;   5'd24: lut = 8'd76;
      5'd23: lut = 8'd64;   5'd22: lut = 8'd54;   5'd21: lut = 8'd45;   5'd20: lut = 8'd38;
      5'd19: lut = 8'd32;   5'd18: lut = 8'd27;   5'd17: lut = 8'd23;   5'd16: lut = 8'd19;
      5'd15: lut = 8'd16;   5'd14: lut = 8'd14;   5'd13: lut = 8'd11;   5'd12: lut = 8'd10;
      5'd11: lut = 8'd8;    5'd10: lut = 8'd7;    5'd9:  lut = 8'd6;    5'd8:  lut = 8'd5;
      5'd7:  lut = 8'd4;    5'd6:  lut = 8'd3;    5'd5:  lut = 8'd3;    5'd4:  lut = 8'd2;
      5'd3:  lut = 8'd2;    5'd2:  lut = 8'd2;    5'd1:  lut = 8'd1;
      default: lut = 8'd0;
    endcase
  endfunction

  state_t     state_reg, state_next;
  logic [9:0] acc_reg, acc_next;
  logic [4:0] snap_a_reg, snap_b_reg, snap_c_reg;
  logic [2:0] mute_reg;
  logic [7:0] dout_reg, dout_next;
  logic       dout_cen_reg, dout_cen_next;
  logic       snapshot_en;

  logic [4:0] vol_sel;
  logic       mute_sel;
  logic [7:0] amp;
  logic [9:0] scaled;
  logic [7:0] sat;

  // Channel feeding the adder this cycle
  always_comb begin
    vol_sel  = snap_a_reg;
    mute_sel = mute_reg[0];
    case (state_reg)
      ACC_B: begin
        vol_sel  = snap_b_reg;
        mute_sel = mute_reg[1];
      end
      ACC_C: begin
        vol_sel  = snap_c_reg;
        mute_sel = mute_reg[2];
      end
      default: ;
    endcase
  end

  assign amp    = mute_sel ? 8'd0 : lut(vol_sel);
  // 765*15 fits in 14 bits, so the product never overflows before the shift
  assign scaled = 10'((14'(acc_reg) * 14'(GAIN_W)) >> 4);
  assign sat    = (scaled > 10'd255) ? 8'd255 : scaled[7:0];

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    dout_next     = dout_reg;
    dout_cen_next = 1'b0;
    snapshot_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cen) begin
          snapshot_en = 1'b1;
          acc_next    = 10'd0;
          state_next  = ACC_A;
        end
      end
      ACC_A: begin
        acc_next   = acc_reg + 10'(amp);
        state_next = ACC_B;
      end
      ACC_B: begin
        acc_next   = acc_reg + 10'(amp);
        state_next = ACC_C;
      end
      ACC_C: begin
        acc_next   = acc_reg + 10'(amp);
        state_next = OUT;
      end
      OUT: begin
        dout_next     = sat;
        dout_cen_next = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= 10'd0;
      snap_a_reg   <= 5'd0;
      snap_b_reg   <= 5'd0;
      snap_c_reg   <= 5'd0;
      mute_reg     <= 3'd0;
      dout_reg     <= 8'd0;
      dout_cen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      dout_reg     <= dout_next;
      dout_cen_reg <= dout_cen_next;
      if (snapshot_en) begin
        snap_a_reg <= vola;
        snap_b_reg <= volb;
        snap_c_reg <= volc;
        mute_reg   <= mute;
      end
    end
  end

  assign dout     = dout_reg;
  assign dout_cen = dout_cen_reg;

`ifdef JT49_MIX_PEAK_EN
  logic [7:0] peak_reg;

  // Clear beats a same-cycle update so software can restart a measurement window cleanly
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 peak_reg <= 8'd0;
    else if (peak_clr)                       peak_reg <= 8'd0;
    else if (dout_cen_next && sat > peak_reg) peak_reg <= sat;
  end

  assign peak = peak_reg;
`endif

endmodule
